// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: opcodes, FSM states,
// datapath select codes and the control-vector struct. Honours MC_CTRL_JAL_EN.
package multicycle_ctrl_fsm_pkg;

  localparam int unsigned OP_LW  = 3;
  localparam int unsigned OP_SW  = 35;
  localparam int unsigned OP_R   = 51;
  localparam int unsigned OP_I   = 19;
  localparam int unsigned OP_BEQ = 99;
  localparam int unsigned OP_JAL = 111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_ILLEGAL,
    S_FAULT
`ifdef MC_CTRL_JAL_EN
    , S_JAL
`endif
  } state_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    A_PC    = 2'b00,
    A_OLDPC = 2'b01,
    A_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    B_RS2  = 2'b00,
    B_IMM  = 2'b01,
    B_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic        pc_update;
    logic        branch;
    logic        reg_write;
    logic        mem_write;
    logic        ir_write;
    logic        adr_src;
    result_src_e result_src;
    src_a_e      alu_src_a;
    src_b_e      alu_src_b;
    alu_op_e     alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // States that wait on the memory handshake and therefore feed the stall timer.
  function automatic logic is_mem_wait_state(input state_e s);
    return (s inside {S_FETCH, S_MEMREAD, S_MEMWRITE});
  endfunction

  function automatic logic is_retire_state(input state_e s);
    return (s inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ});
  endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode -> immediate-format select, shared with the single-cycle core.
// J-format is only decoded when MC_CTRL_JAL_EN is defined.
module imm_src_decoder
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int OP_W = 7
) (
  input  logic [OP_W-1:0] op_i,
  output logic [1:0]      imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_W'(OP_SW):  imm_src_o = IMM_S;
      OP_W'(OP_BEQ): imm_src_o = IMM_B;
`ifdef MC_CTRL_JAL_EN
      OP_W'(OP_JAL): imm_src_o = IMM_J;
`endif
      default:       imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RISC-V control FSM with memory wait states, stall timeout, illegal-opcode
// trap and retired-instruction counter. Define MC_CTRL_JAL_EN to add the JAL sequence.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int OP_W      = 7,
  parameter int STALL_MAX = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             pc_update,
  output logic             branch,
  output logic             reg_write,
  output logic             mem_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             illegal_op,
  output logic             timeout,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic              stalled;
  logic              stall_limit;
  logic              retire;
  ctrl_t             ctrl;

  assign stalled     = is_mem_wait_state(state_q) && !mem_ready;
  assign stall_limit = (STALL_MAX != 0) && stalled &&
                       (wait_q == WAIT_W'(STALL_MAX - 1));

  // State register and the counters/flags that travel with it.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output is given a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_W'(OP_LW),
          OP_W'(OP_SW):  state_d = S_MEMADR;
          OP_W'(OP_R):   state_d = S_EXECR;
          OP_W'(OP_I):   state_d = S_EXECI;
          OP_W'(OP_BEQ): state_d = S_BEQ;
`ifdef MC_CTRL_JAL_EN
          OP_W'(OP_JAL): state_d = S_JAL;
`endif
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_W'(OP_SW)) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef MC_CTRL_JAL_EN
      S_JAL:      state_d = S_ALUWB;
`endif
      S_ILLEGAL:  state_d = S_ILLEGAL;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FETCH;
    endcase
    if (stall_limit) state_d = S_FAULT;
  end

  // Stall timer restarts whenever the state moves on; instret counts completed instructions.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (stalled) begin
      wait_d = wait_q + 1'b1;
    end
    retire    = (state_d == S_FETCH) && is_retire_state(state_q);
    instret_d = instret_q + CNT_W'(retire);
    illegal_d = illegal_q || (state_d == S_ILLEGAL);
    timeout_d = timeout_q || (state_d == S_FAULT);
  end

  // Output decode: Moore from state, except the FETCH write enables follow mem_ready
  // and are held low while reset is asserted.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_q)
      S_FETCH: begin
        ctrl.alu_src_b  = B_FOUR;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = mem_ready && !reset;
        ctrl.pc_update  = mem_ready && !reset;
      end
      S_DECODE: begin
        ctrl.alu_src_a = A_OLDPC;
        ctrl.alu_src_b = B_IMM;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
      end
      S_MEMREAD: begin
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_src_b = B_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = A_RS1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        ctrl.alu_src_a = A_OLDPC;
        ctrl.alu_src_b = B_FOUR;
        ctrl.pc_update = 1'b1;
      end
`endif
      default: ctrl = CTRL_IDLE;
    endcase
  end

  imm_src_decoder #(
    .OP_W(OP_W)
  ) u_imm_src_decoder (
    .op_i      (op),
    .imm_src_o (imm_src)
  );

  assign pc_update  = ctrl.pc_update;
  assign branch     = ctrl.branch;
  assign reg_write  = ctrl.reg_write;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign adr_src    = ctrl.adr_src;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal_op = illegal_q;
  assign timeout    = timeout_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed scenarios plus random opcodes and
// memory wait states, checked every cycle against a microprogram-table reference model.
module tb_multicycle_ctrl_fsm;

  localparam int OP_W      = 7;
  localparam int STALL_MAX = 4;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [OP_W-1:0]  op;
  logic             mem_ready;
  logic             pc_update, branch, reg_write, mem_write, ir_write, adr_src;
  logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic             illegal_op, timeout;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl_fsm #(
    .OP_W(OP_W), .STALL_MAX(STALL_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_update(pc_update), .branch(branch), .reg_write(reg_write),
    .mem_write(mem_write), .ir_write(ir_write), .adr_src(adr_src),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src), .illegal_op(illegal_op),
    .timeout(timeout), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_update, branch, reg_write, mem_write, ir_write, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  } vec_t;

  // One micro-step of an instruction: its control vector, whether it waits on memory,
  // and whether its IR/PC enables follow mem_ready.
  typedef struct packed {
    logic waits;
    logic gated;
    vec_t c;
  } step_t;

  int n_cmp = 0;
  int n_bad = 0;

  step_t st_fetch, st_decode, st_memadr, st_memread, st_memwb, st_memwrite;
  step_t st_execr, st_execi, st_aluwb, st_beq, st_jal;
  step_t prog[$];
  int          idx;
  int          stall;
  bit          dead_ill, dead_to;
  int unsigned icnt;
  bit          cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic step_t mk(input logic w, g, pcu, br, rw, mw, adr,
                               input logic [1:0] rs, a, b, aop);
    step_t s;
    s = '0;
    s.waits = w;
    s.gated = g;
    s.c.pc_update = pcu;
    s.c.branch = br;
    s.c.reg_write = rw;
    s.c.mem_write = mw;
    s.c.adr_src = adr;
    s.c.result_src = rs;
    s.c.alu_src_a = a;
    s.c.alu_src_b = b;
    s.c.alu_op = aop;
    return s;
  endfunction

  task automatic model_reset();
    prog.delete();
    prog.push_back(st_fetch);
    prog.push_back(st_decode);
    idx = 0;
    stall = 0;
    dead_ill = 1'b0;
    dead_to = 1'b0;
    icnt = 0;
  endtask

  task automatic model_step();
    step_t s;
    if (dead_ill || dead_to) return;
    s = prog[idx];
    if (s.waits && !mem_ready) begin
      stall++;
      if (stall == STALL_MAX) dead_to = 1'b1;
      return;
    end
    stall = 0;
    if (idx == 1) begin
      case (int'(op))
        3:   begin prog.push_back(st_memadr); prog.push_back(st_memread); prog.push_back(st_memwb); end
        35:  begin prog.push_back(st_memadr); prog.push_back(st_memwrite); end
        51:  begin prog.push_back(st_execr); prog.push_back(st_aluwb); end
        19:  begin prog.push_back(st_execi); prog.push_back(st_aluwb); end
        99:  prog.push_back(st_beq);
`ifdef MC_CTRL_JAL_EN
        111: begin prog.push_back(st_jal); prog.push_back(st_aluwb); end
`endif
        default: begin dead_ill = 1'b1; return; end
      endcase
    end
    idx++;
    if (idx == prog.size()) begin
      icnt++;
      prog.delete();
      prog.push_back(st_fetch);
      prog.push_back(st_decode);
      idx = 0;
    end
  endtask

  function automatic vec_t exp_vec();
    vec_t  e;
    step_t s;
    if (dead_ill || dead_to) return '0;
    s = prog[idx];
    e = s.c;
    if (s.gated) begin
      e.ir_write  = mem_ready && !reset;
      e.pc_update = mem_ready && !reset;
    end
    return e;
  endfunction

  function automatic logic [1:0] exp_imm(input logic [OP_W-1:0] o);
    case (int'(o))
      35: return 2'b01;
      99: return 2'b10;
`ifdef MC_CTRL_JAL_EN
      111: return 2'b11;
`endif
      default: return 2'b00;
    endcase
  endfunction

  function automatic vec_t dut_vec();
    return {pc_update, branch, reg_write, mem_write, ir_write, adr_src,
            result_src, alu_src_a, alu_src_b, alu_op};
  endfunction

  // Reference model advances on every clock edge and on reset assertion.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    wait (cmp_en);
    forever begin
      @(negedge clk);
      check("ctrl_vec", 32'(dut_vec()), 32'(exp_vec()));
      check("imm_src", 32'(imm_src), 32'(exp_imm(op)));
      check("illegal_op", 32'(illegal_op), 32'(dead_ill));
      check("timeout", 32'(timeout), 32'(dead_to));
      check("instret", 32'(instret), icnt % 32'(1 << CNT_W));
    end
  end

  task automatic cyc(input logic [OP_W-1:0] o, input logic r);
    @(posedge clk); #1;
    op = o;
    mem_ready = r;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk); #1;
    check("rst_ir_write", 32'(ir_write), 0);
    check("rst_pc_update", 32'(pc_update), 0);
    check("rst_instret", 32'(instret), 0);
    check("rst_flags", 32'({illegal_op, timeout}), 0);
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic run_rtype();
    cyc(7'd51, 1'b1); check("r_fetch_ir", 32'(ir_write), 1);
    cyc(7'd51, 1'b1); check("r_decode_a", 32'(alu_src_a), 1);
    cyc(7'd51, 1'b1); check("r_exec_aluop", 32'(alu_op), 2);
    cyc(7'd51, 1'b1); check("r_wb_regwrite", 32'(reg_write), 1);
  endtask

  logic [OP_W-1:0] legal_ops [11] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99,
                                      7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111};
  logic [OP_W-1:0] bad_ops [4] = '{7'h7F, 7'h00, 7'h17, 7'h67};

  initial begin
    logic [OP_W-1:0] o;
    int dead_cyc;
    st_fetch    = mk(1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00);
    st_decode   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    st_memadr   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
    st_memread  = mk(1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    st_memwb    = mk(0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    st_memwrite = mk(1, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    st_execr    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
    st_execi    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10);
    st_aluwb    = mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    st_beq      = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01);
    st_jal      = mk(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
    op = '0;
    mem_ready = 1'b0;
    model_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    do_reset();

    // R-type, then lw with two wait states, then beq.
    run_rtype();
    cyc(7'd3, 1'b1);  check("r_retired", 32'(instret), 1);
                      check("r_next_regwrite", 32'(reg_write), 0);
    cyc(7'd3, 1'b1);  check("lw_decode_imm", 32'(imm_src), 0);
    cyc(7'd3, 1'b1);  check("lw_memadr_a", 32'(alu_src_a), 2);
    cyc(7'd3, 1'b0);  check("lw_memread_adr1", 32'(adr_src), 1);
    cyc(7'd3, 1'b0);  check("lw_memread_adr2", 32'(adr_src), 1);
    cyc(7'd3, 1'b1);  check("lw_memread_adr3", 32'(adr_src), 1);
    cyc(7'd3, 1'b1);  check("lw_memwb", 32'({reg_write, result_src}), 32'({1'b1, 2'b01}));
    cyc(7'd99, 1'b1); check("lw_retired", 32'(instret), 2);
    cyc(7'd99, 1'b1); check("beq_decode_imm", 32'(imm_src), 2);
    cyc(7'd99, 1'b1); check("beq_branch", 32'({branch, alu_op}), 32'({1'b1, 2'b01}));
    cyc(7'd111, 1'b1); check("beq_retired", 32'(instret), 3);

    // JAL with the feature enabled, illegal otherwise.
    cyc(7'd111, 1'b1);
`ifdef MC_CTRL_JAL_EN
    check("jal_decode_imm", 32'(imm_src), 3);
    cyc(7'd111, 1'b1); check("jal_pc_update", 32'({pc_update, alu_src_a, alu_src_b}), 32'({1'b1, 2'b01, 2'b10}));
    cyc(7'd111, 1'b1); check("jal_aluwb", 32'(reg_write), 1);
    cyc(7'd111, 1'b0); check("jal_retired", 32'(instret), 4);
`else
    check("jal_decode_imm", 32'(imm_src), 0);
    cyc(7'd111, 1'b1); check("jal_illegal", 32'(illegal_op), 1);
    cyc(7'd111, 1'b1); check("jal_illegal_pc", 32'(pc_update), 0);
`endif

    // Reset asserted in the middle of a store.
    do_reset();
    run_rtype();
    cyc(7'd35, 1'b1); check("sw_fetch_count", 32'(instret), 1);
    cyc(7'd35, 1'b1); check("sw_decode_imm", 32'(imm_src), 1);
    cyc(7'd35, 1'b1);
    cyc(7'd35, 1'b0); check("sw_memwrite", 32'(mem_write), 1);
    reset = 1'b1;
    #1;
    check("midrst_memwrite", 32'(mem_write), 0);
    check("midrst_instret", 32'(instret), 0);
    check("midrst_fetch_sel", 32'({alu_src_b, result_src}), 32'({2'b10, 2'b10}));
    @(negedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;

    // Store that never completes: four held cycles, then FAULT.
    cyc(7'd35, 1'b1);
    cyc(7'd35, 1'b1);
    cyc(7'd35, 1'b1);
    for (int i = 0; i < STALL_MAX; i++) begin
      cyc(7'd35, 1'b0); check("to_memwrite_held", 32'(mem_write), 1);
    end
    cyc(7'd35, 1'b0); check("to_fault", 32'({timeout, mem_write}), 32'({1'b1, 1'b0}));
    cyc(7'd35, 1'b1); check("to_sticky", 32'({timeout, ir_write}), 32'({1'b1, 1'b0}));

    // Undecodable opcode.
    do_reset();
    cyc(7'h7F, 1'b1);
    cyc(7'h7F, 1'b1);
    cyc(7'h7F, 1'b1); check("ill_flag", 32'({illegal_op, pc_update}), 32'({1'b1, 1'b0}));
    cyc(7'h7F, 1'b1); check("ill_no_fetch", 32'({ir_write, pc_update}), 0);

    // Random opcodes and memory wait states.
    do_reset();
    dead_cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (dead_ill || dead_to) begin
        dead_cyc++;
        if (dead_cyc > 3) begin
          do_reset();
          dead_cyc = 0;
          continue;
        end
      end
      o = op;
      if (idx == 0) begin
        if ($urandom_range(63) == 0) o = bad_ops[$urandom_range(3)];
        else o = legal_ops[$urandom_range(10)];
      end
      cyc(o, $urandom_range(3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
